// File: rtl/exec_sequencer_if.sv
// Control/status bundle between the execution sequencer and its environment.
// The master side drives the tick, step key, switches, breakpoint and next-PC inputs; the slave side returns status.
interface exec_sequencer_if #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
);
  logic             tick;
  logic             step_n;
  logic             run_sw;
  logic             bp_en;
  logic [PC_W-1:0]  bp_addr;
  logic [PC_W-1:0]  pc_next;
  logic             commit;
  logic             busy;
  logic             halted;
  logic             missed;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output tick, step_n, run_sw, bp_en, bp_addr, pc_next,
    input  commit, busy, halted, missed, state, instr_cnt
  );

  modport slave (
    input  tick, step_n, run_sw, bp_en, bp_addr, pc_next,
    output commit, busy, halted, missed, state, instr_cnt
  );
endinterface

// File: rtl/exec_sequencer.sv
// Run/step/breakpoint sequencer: one commit strobe per instruction, ROM_LAT+1 cycles after the trigger.
// No backpressure: triggers arriving while busy are dropped (ticks flag the sticky missed bit).
module exec_sequencer #(
  parameter int PC_W    = 8,
  parameter int CNT_W   = 16,
  parameter int ROM_LAT = 2,
  parameter int DB_CYC  = 250000
) (
  input logic            clk,
  input logic            rst,
  exec_sequencer_if.slave sq
);
  localparam int DB_W = $clog2(DB_CYC + 1);

  typedef enum logic [2:0] {
    PAUSE  = 3'd0,
    RUN    = 3'd1,
    FETCH  = 3'd2,
    COMMIT = 3'd3,
    BRK    = 3'd4
  } state_t;

  state_t           st, nxt;
  logic [3:0]       wcnt, wcnt_nxt;
  logic             mode, mode_nxt;     // 1 = fetch came from run mode, 0 = from step
  logic             run_q;
  logic             s1, s2, filt, filt_d;
  logic [DB_W-1:0]  db_cnt;
  logic             step_p;
  logic             bp_hit;
  logic [PC_W-1:0]  pc_cmp;
  logic             commit_q, busy_q, halted_q, missed_q;
  logic [CNT_W-1:0] cnt_q;

  assign step_p = filt_d & ~filt;
  assign pc_cmp = sq.pc_next;
  assign bp_hit = sq.bp_en && (pc_cmp == sq.bp_addr);

  // Step key: synchronize, then accept a new level only after DB_CYC stable cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      filt   <= 1'b1;
      filt_d <= 1'b1;
      db_cnt <= '0;
    end else begin
      s1     <= sq.step_n;
      s2     <= s1;
      filt_d <= filt;
      if (s2 == filt) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DB_CYC - 1)) begin
        filt   <= s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    nxt      = st;
    wcnt_nxt = wcnt;
    mode_nxt = mode;
    case (st)
      PAUSE: begin
        if (sq.run_sw) begin
          nxt = RUN;
        end else if (step_p) begin
          nxt      = FETCH;
          mode_nxt = 1'b0;
        end
      end
      RUN: begin
        if (!sq.run_sw) begin
          nxt = PAUSE;
        end else if (sq.tick) begin
          nxt      = FETCH;
          mode_nxt = 1'b1;
        end
      end
      FETCH: begin
        if (wcnt == 4'd0) nxt = COMMIT;
        else              wcnt_nxt = wcnt - 4'd1;
      end
      COMMIT: begin
        if (bp_hit)                   nxt = BRK;
        else if (mode && sq.run_sw)   nxt = RUN;
        else                          nxt = PAUSE;
      end
      BRK: begin
        if (step_p) begin
          nxt      = FETCH;
          mode_nxt = 1'b0;
        end else if (run_q && !sq.run_sw) begin
          nxt = PAUSE;
        end
      end
      default: nxt = PAUSE;
    endcase
    if (nxt == FETCH && st != FETCH) wcnt_nxt = 4'(ROM_LAT - 1);
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= PAUSE;
      wcnt     <= '0;
      mode     <= 1'b0;
      run_q    <= 1'b0;
      commit_q <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      missed_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      st       <= nxt;
      wcnt     <= wcnt_nxt;
      mode     <= mode_nxt;
      run_q    <= sq.run_sw;
      commit_q <= (nxt == COMMIT);
      busy_q   <= (nxt == FETCH) || (nxt == COMMIT);
      halted_q <= (nxt == BRK);
      if (sq.tick && (st == FETCH || st == COMMIT)) missed_q <= 1'b1;
      if (nxt == COMMIT && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign sq.commit    = commit_q;
  assign sq.busy      = busy_q;
  assign sq.halted    = halted_q;
  assign sq.missed    = missed_q;
  assign sq.state     = st;
  assign sq.instr_cnt = cnt_q;
endmodule
